// File: rtl/npc_redirect_unit_if.sv
// Bundle between the D-stage decode/forwarding logic, the instruction memory
// and the next-PC unit. The unit itself uses the slave side.
interface npc_redirect_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              stall_d;
    logic              imem_ready;
    logic              d_valid;
    logic [ADDR_W-1:0] pc_d;
    logic [31:0]       instr_d;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [3:0]        npc_op;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] pc_f;
    logic              redirect;
    logic [ADDR_W-1:0] link_addr;
    logic              pending_valid;

    modport master (
        output stall_d, imem_ready, d_valid, pc_d, instr_d, rs_data, rt_data,
               npc_op, exc_req, eret_req, epc,
        input  pc_f, redirect, link_addr, pending_valid
    );

    modport slave (
        input  stall_d, imem_ready, d_valid, pc_d, instr_d, rs_data, rt_data,
               npc_op, exc_req, eret_req, epc,
        output pc_f, redirect, link_addr, pending_valid
    );
endinterface

// File: rtl/npc_redirect_unit.sv
// Fetch-PC owner: resolves MIPS branches/jumps in D, handles exception entry
// and eret, and buffers one redirect while instruction memory is not ready.
module npc_redirect_unit #(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_4180)
) (
    input  logic               clk,
    input  logic               reset,
    npc_redirect_unit_if.slave bus
);
    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BNE  = 4'd2;
    localparam logic [3:0] OP_BLEZ = 4'd3;
    localparam logic [3:0] OP_BGTZ = 4'd4;
    localparam logic [3:0] OP_BLTZ = 4'd5;
    localparam logic [3:0] OP_BGEZ = 4'd6;
    localparam logic [3:0] OP_J    = 4'd7;
    localparam logic [3:0] OP_JR   = 4'd8;

    logic [ADDR_W-1:0] pc_f_q, pc_f_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic              cond_met;
    logic              taken;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] target;
    logic signed [31:0] rs_s;

    // Opcode field is decoded upstream into npc_op; only offset/index bits matter here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr_d[31:26];

    assign rs_s = signed'(bus.rs_data);

    // Branch offset is sign-extended word offset relative to the delay slot.
    assign br_target = bus.pc_d + ADDR_W'(4)
                     + {{(ADDR_W-18){bus.instr_d[15]}}, bus.instr_d[15:0], 2'b00};

    // Jump region comes from the D-stage PC, not the fetch PC.
    always_comb begin
        j_target        = bus.pc_d;
        j_target[27:0]  = {bus.instr_d[25:0], 2'b00};
    end

    // Branch condition and target selection from raw forwarded operands.
    always_comb begin
        cond_met = 1'b0;
        target   = br_target;
        case (bus.npc_op)
            OP_BEQ:  cond_met = (bus.rs_data == bus.rt_data);
            OP_BNE:  cond_met = (bus.rs_data != bus.rt_data);
            OP_BLEZ: cond_met = (rs_s <= 32'sd0);
            OP_BGTZ: cond_met = (rs_s >  32'sd0);
            OP_BLTZ: cond_met = (rs_s <  32'sd0);
            OP_BGEZ: cond_met = (rs_s >= 32'sd0);
            OP_J: begin
                cond_met = 1'b1;
                target   = j_target;
            end
            OP_JR: begin
                cond_met = 1'b1;
                target   = ADDR_W'(bus.rs_data);
            end
            default: cond_met = 1'b0;
        endcase
    end

    assign taken = bus.d_valid & ~bus.stall_d & cond_met;

    // Next fetch PC and pending-buffer update; earlier rules take priority.
    always_comb begin
        pc_f_d        = pc_f_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (bus.exc_req) begin
            pc_f_d       = EXC_VECTOR;
            pend_valid_d = 1'b0;
        end else if (bus.eret_req) begin
            pc_f_d       = bus.epc;
            pend_valid_d = 1'b0;
        end else if (bus.stall_d) begin
            // F and D frozen: hold everything.
        end else if (!bus.imem_ready) begin
            if (taken) begin
                pend_valid_d  = 1'b1;
                pend_target_d = target;
            end
        end else if (taken) begin
            // A live redirect beats a stale buffered one.
            pc_f_d       = target;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_f_d       = pend_target_q;
            pend_valid_d = 1'b0;
        end else begin
            pc_f_d = pc_f_q + ADDR_W'(4);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q        <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_f_q        <= pc_f_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.pc_f          = pc_f_q;
    assign bus.redirect      = taken;
    assign bus.link_addr     = bus.pc_d + ADDR_W'(8);
    assign bus.pending_valid = pend_valid_q;
endmodule

// File: doc/npc_redirect_unit.md
Name: npc_redirect_unit

Overview:
- Parametrised next-generation fetch-PC unit. Owns the F-stage PC register, resolves every MIPS branch/jump class in D from raw register operands, and provides the link address.
- Handles exception entry and eret.
- Holds a one-entry pending-redirect buffer, so a redirect resolved while fetch is blocked by an instruction-memory wait is not lost.
- Sits between the D-stage decoder/forwarding muxes and the instruction memory.

Parameters:
- ADDR_W, 32, PC/address width (ADDR_W >= 28).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception entry.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall_d  input  1  D stage frozen by the hazard unit; F and D hold.
- imem_ready  input  1  instruction memory accepts the fetch address this cycle.
- d_valid  input  1  D holds a real instruction (0 = bubble).
- pc_d  input  ADDR_W  PC of the D-stage instruction.
- instr_d  input  32  D-stage instruction word.
- rs_data  input  32  forwarded rs operand.
- rt_data  input  32  forwarded rt operand.
- npc_op  input  4  0 seq, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j/jal, 8 jr/jalr; 9-15 treated as 0.
- exc_req  input  1  exception taken this cycle.
- eret_req  input  1  eret committed this cycle.
- epc  input  ADDR_W  return PC for eret.
- pc_f  output  ADDR_W  current fetch PC (registered).
- redirect  output  1  D-stage control transfer taken this cycle (combinational).
- link_addr  output  ADDR_W  pc_d + 8.
- pending_valid  output  1  buffered redirect waiting for imem_ready.

Behaviour:
- Reset (async, any time, including mid-wait): pc_f = RESET_PC; pending_valid = 0; pending target = 0. redirect and link_addr remain combinational.
- Branch target = pc_d + 4 + (sign-extended instr_d[15:0] << 2), wrapped modulo 2^ADDR_W.
- Jump target = {pc_d[ADDR_W-1:28], instr_d[25:0], 2'b00}. The upper bits come from pc_d, not pc_f.
- jr target = rs_data[ADDR_W-1:0].
- Conditions (signed 32-bit):
  - beq: rs == rt.
  - bne: rs != rt.
  - blez: rs <= 0.
  - bgtz: rs > 0.
  - bltz: rs < 0.
  - bgez: rs >= 0.
- taken = d_valid & !stall_d & condition met. Ops 7 and 8 are always met.
- redirect = taken. The target is the matching target above.
- pc_f update each rising edge, first matching rule wins:
  1. exc_req: pc_f <= EXC_VECTOR; pending cleared.
  2. eret_req: pc_f <= epc; pending cleared.
  3. stall_d: pc_f and pending hold.
  4. imem_ready = 0:
     - pc_f holds.
     - If taken, pending_valid <= 1 and pending target <= target. A later taken overwrites it; a single entry is sufficient because D is a bubble while fetch is blocked.
  5. imem_ready = 1 with pending_valid: pc_f <= pending target; pending_valid <= 0. A simultaneous taken cannot occur (D is a bubble); if it does, taken wins.
  6. imem_ready = 1, taken: pc_f <= target.
  7. Otherwise: pc_f <= pc_f + 4, wrapping at 2^ADDR_W.
- Delay slot: the fetch already issued at pc_f is kept. No squash is generated by this block.
- Latency: a redirect resolved in cycle N is visible on pc_f in cycle N+1 when imem_ready = 1. Otherwise it appears the first cycle after imem_ready returns to 1.
- exc_req and eret_req asserted together: exc_req wins.
- No combinational path from pc_f to redirect.

Test Plan:
- Reset async pulse mid-cycle, then 3 cycles with imem_ready = 1 and npc_op = 0 -> pc_f 0x3000 immediately, then 0x3004, 0x3008, 0x300C.
- beq, pc_d = 0x3010, imm = 0xFFFC, rs = rt = 5 -> redirect = 1, next pc_f = 0x3004. Same case with rt = 6 -> redirect = 0, pc_f += 4.
- bltz with rs = 0x8000_0000 -> taken. bgtz with rs = 0 -> not taken. blez with rs = 0 -> taken. link_addr = pc_d + 8 in each case.
- jal 0x0C00_1000 from pc_d = 0x3000 -> pc_f = 0x0000_4000. jr with rs = 0x3ABC -> pc_f = 0x3ABC.
- imem_ready = 0 while jal resolves -> pending_valid = 1, pc_f holds. Two cycles later imem_ready = 1 -> pc_f = target, pending_valid = 0.
- exc_req with eret_req and stall_d = 1 in the same cycle, pending set -> pc_f = 0x4180, pending_valid = 0. Next, eret_req with epc = 0x3020 -> pc_f = 0x3020.
